memory_access: RTL and testbench

// MEM stage of the mycpu pipeline: consumes the EX result (address/ALU value, rd, store data) and

---
 rtl/memory_access_pkg.sv | 70 +++++++
 rtl/memory_access_if.sv | 30 +++
 rtl/memory_access_load_extend.sv | 30 +++
 rtl/memory_access.sv | 147 ++++++++++++++
 tb/tb_memory_access.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_access_pkg.sv
// memory_access_pkg
//   Shared types and helpers for the MEM pipeline stage.
//   mem_op_t   : memory operation carried down from EX
//   msize_t    : data-bus transfer size
//   helpers    : load/store classification, transfer size, alignment,
//                byte strobes and lane replication for store data
package memory_access_pkg;

   typedef enum logic [3:0] {
      MEM_NONE = 4'd0,
      MEM_LB   = 4'd1,
      MEM_LBU  = 4'd2,
      MEM_LH   = 4'd3,
      MEM_LHU  = 4'd4,
      MEM_LW   = 4'd5,
      MEM_SB   = 4'd6,
      MEM_SH   = 4'd7,
      MEM_SW   = 4'd8
   } mem_op_t;

   typedef enum logic [1:0] {
      MSIZE_BYTE = 2'd0,
      MSIZE_HALF = 2'd1,
      MSIZE_WORD = 2'd2
   } msize_t;

   function automatic logic mem_op_is_load(mem_op_t op);
      return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
   endfunction

   function automatic logic mem_op_is_store(mem_op_t op);
      return op inside {MEM_SB, MEM_SH, MEM_SW};
   endfunction

   function automatic msize_t mem_op_size(mem_op_t op);
      case (op)
         MEM_LH, MEM_LHU, MEM_SH: return MSIZE_HALF;
         MEM_LW, MEM_SW:          return MSIZE_WORD;
         default:                 return MSIZE_BYTE;
      endcase
   endfunction

   function automatic logic mem_op_misaligned(mem_op_t op, logic [1:0] offset);
      case (mem_op_size(op))
         MSIZE_HALF: return offset[0];
         MSIZE_WORD: return offset != 2'b00;
         default:    return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] mem_op_strobe(mem_op_t op, logic [1:0] offset);
      if (!mem_op_is_store(op)) return 4'b0000;
      case (mem_op_size(op))
         MSIZE_BYTE: return 4'b0001 << offset;
         MSIZE_HALF: return 4'b0011 << offset;
         default:    return 4'b1111;
      endcase
   endfunction

   // Replicate the store operand across all lanes so the bus can pick
   // whichever lanes the strobe enables.
   function automatic logic [31:0] mem_lane_data(msize_t size, logic [31:0] d);
      case (size)
         MSIZE_BYTE: return {4{d[7:0]}};
         MSIZE_HALF: return {2{d[15:0]}};
         default:    return d;
      endcase
   endfunction

endpackage

// File: rtl/memory_access_if.sv
// memory_access_if
//   Data-bus request/response bundle between the MEM stage and memory.
//   master : MEM stage (drives dreq_*, receives dresp_*)
//   slave  : memory side
//   dreq_valid/addr/size/strobe/data : request, held until dresp_addr_ok
//   dresp_addr_ok : request accepted
//   dresp_data_ok : transfer finished; dresp_data valid for loads
interface memory_access_if;
   import memory_access_pkg::*;

   logic        dreq_valid;
   logic [31:0] dreq_addr;
   msize_t      dreq_size;
   logic [3:0]  dreq_strobe;
   logic [31:0] dreq_data;
   logic        dresp_addr_ok;
   logic        dresp_data_ok;
   logic [31:0] dresp_data;

   modport master (
      output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      input  dresp_addr_ok, dresp_data_ok, dresp_data
   );

   modport slave (
      input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
      output dresp_addr_ok, dresp_data_ok, dresp_data
   );

endinterface

// File: rtl/memory_access_load_extend.sv
// memory_access_load_extend
//   Combinational load alignment: shifts the addressed byte/half down to
//   bit 0 and sign- or zero-extends according to the load kind.
//   op     : load operation
//   offset : address bits [1:0]
//   raw    : word returned by the bus
//   result : value for the register file
module memory_access_load_extend
   import memory_access_pkg::*;
(
   input  mem_op_t     op,
   input  logic [1:0]  offset,
   input  logic [31:0] raw,
   output logic [31:0] result
);

   logic [31:0] w;

   always_comb begin
      w = raw >> {offset, 3'b000};
      case (op)
         MEM_LB:  result = {{24{w[7]}}, w[7:0]};
         MEM_LBU: result = {24'd0, w[7:0]};
         MEM_LH:  result = {{16{w[15]}}, w[15:0]};
         MEM_LHU: result = {16'd0, w[15:0]};
         default: result = w;
      endcase
   end

endmodule

// File: rtl/memory_access.sv
// memory_access
//   MEM pipeline stage. Takes the EX result, performs at most one data-bus
//   transaction at a time, and emits a registered one-cycle writeback record.
//   clk, reset                 : clock, synchronous active-high reset
//   in_valid/in_ready          : EX handshake (in_ready low stalls EX)
//   memop, rd_in, alu_out, store_data : instruction from EX
//   bus                        : data-bus master port
//   wb_valid/wb_wen/wb_rd/wb_result   : writeback record
//   misalign                   : address fault flag, pulses with wb_valid
//
// state | meaning
// IDLE  | ready for a new instruction
// ADDR  | request on the bus, waiting for addr_ok
// DATA  | request accepted, waiting for data_ok
module memory_access
   import memory_access_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  mem_op_t              memop,
   input  logic [4:0]           rd_in,
   input  logic [31:0]          alu_out,
   input  logic [31:0]          store_data,
   memory_access_if.master      bus,
   output logic                 wb_valid,
   output logic                 wb_wen,
   output logic [4:0]           wb_rd,
   output logic [31:0]          wb_result,
   output logic                 misalign
);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

   state_t      state_q, state_d;
   mem_op_t     op_q;
   logic [31:0] addr_q, data_q;
   logic [4:0]  rd_q;

   logic        accept_mem;
   logic        done;
   logic        wb_valid_d, wb_wen_d, misalign_d;
   logic [4:0]  wb_rd_d;
   logic [31:0] wb_result_d;
   logic [31:0] load_result;

   memory_access_load_extend u_load_extend (
      .op     (op_q),
      .offset (addr_q[1:0]),
      .raw    (bus.dresp_data),
      .result (load_result)
   );

   assign in_ready        = (state_q == S_IDLE);
   assign bus.dreq_valid  = (state_q == S_ADDR);
   assign bus.dreq_addr   = addr_q;
   assign bus.dreq_size   = mem_op_size(op_q);
   assign bus.dreq_strobe = mem_op_strobe(op_q, addr_q[1:0]);
   assign bus.dreq_data   = mem_lane_data(mem_op_size(op_q), data_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         op_q      <= MEM_NONE;
         addr_q    <= '0;
         data_q    <= '0;
         rd_q      <= '0;
         wb_valid  <= 1'b0;
         wb_wen    <= 1'b0;
         wb_rd     <= '0;
         wb_result <= '0;
         misalign  <= 1'b0;
      end else begin
         state_q   <= state_d;
         wb_valid  <= wb_valid_d;
         wb_wen    <= wb_wen_d;
         wb_rd     <= wb_rd_d;
         wb_result <= wb_result_d;
         misalign  <= misalign_d;
         if (accept_mem) begin
            op_q   <= memop;
            addr_q <= alu_out;
            data_q <= store_data;
            rd_q   <= rd_in;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      accept_mem  = 1'b0;
      done        = 1'b0;
      wb_valid_d  = 1'b0;
      wb_wen_d    = 1'b0;
      misalign_d  = 1'b0;
      wb_rd_d     = wb_rd;
      wb_result_d = wb_result;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (memop == MEM_NONE) begin
                  wb_valid_d  = 1'b1;
                  wb_wen_d    = (rd_in != 5'd0);
                  wb_rd_d     = rd_in;
                  wb_result_d = alu_out;
               end else if (mem_op_misaligned(memop, alu_out[1:0])) begin
                  // Faulting address is reported as the result; no bus access.
                  wb_valid_d  = 1'b1;
                  misalign_d  = 1'b1;
                  wb_rd_d     = rd_in;
                  wb_result_d = alu_out;
               end else begin
                  accept_mem = 1'b1;
                  state_d    = S_ADDR;
               end
            end
         end
         S_ADDR: begin
            if (bus.dresp_addr_ok) begin
               if (bus.dresp_data_ok) begin
                  done    = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (bus.dresp_data_ok) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (done) begin
         wb_valid_d  = 1'b1;
         wb_wen_d    = mem_op_is_load(op_q) && (rd_q != 5'd0);
         wb_rd_d     = rd_q;
         wb_result_d = mem_op_is_load(op_q) ? load_result : data_q;
      end
   end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;
   import memory_access_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   mem_op_t     memop;
   logic [4:0]  rd_in;
   logic [31:0] alu_out;
   logic [31:0] store_data;
   logic        wb_valid, wb_wen, misalign;
   logic [4:0]  wb_rd;
   logic [31:0] wb_result;

   memory_access_if bus();

   memory_access dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .memop      (memop),
      .rd_in      (rd_in),
      .alu_out    (alu_out),
      .store_data (store_data),
      .bus        (bus),
      .wb_valid   (wb_valid),
      .wb_wen     (wb_wen),
      .wb_rd      (wb_rd),
      .wb_result  (wb_result),
      .misalign   (misalign)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Observations of the most recent instruction.
   int          o_k, o_req, o_stall, o_unst;
   logic        o_wen, o_mis;
   logic [4:0]  o_rd;
   logic [31:0] o_res, o_addr, o_data;
   logic [1:0]  o_size;
   logic [3:0]  o_strb;

   // data_ok without addr_ok while a request is outstanding is illegal.
   always @(posedge clk) begin
      if (!reset && bus.dreq_valid && bus.dresp_data_ok && !bus.dresp_addr_ok) begin
         bad++;
         $display("FAIL bus_protocol: data_ok=1 addr_ok=0 while request pending");
      end
   end

   // ---------------- reference model ----------------
   function automatic int m_bytes(int op);
      case (op)
         1, 2, 6: return 1;
         3, 4, 7: return 2;
         5, 8:    return 4;
         default: return 0;
      endcase
   endfunction

   function automatic bit m_is_load(int op);
      return op >= 1 && op <= 5;
   endfunction

   function automatic bit m_misaligned(int op, logic [31:0] a);
      int n = m_bytes(op);
      return n > 1 && (a % n) != 0;
   endfunction

   function automatic logic [31:0] m_load_val(int op, logic [31:0] a, logic [31:0] raw);
      int n = m_bytes(op);
      longint unsigned w, lim;
      w   = {32'd0, raw} >> (8 * (a % 4));
      lim = 64'd1 << (8 * n);
      w   = w % lim;
      if ((op == 1 || op == 3) && w >= lim / 2) w = w + (64'h1_0000_0000 - lim);
      return w[31:0];
   endfunction

   function automatic logic [3:0] m_strobe(int op, logic [31:0] a);
      int s;
      if (op < 6) return 4'b0000;
      s = ((1 << m_bytes(op)) - 1) << (a % 4);
      return s[3:0];
   endfunction

   function automatic logic [31:0] m_lane(int op, logic [31:0] d);
      case (m_bytes(op))
         1:       return d[7:0] * 32'h0101_0101;
         2:       return d[15:0] * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   function automatic logic [1:0] m_size(int op);
      case (m_bytes(op))
         1:       return 2'd0;
         2:       return 2'd1;
         default: return 2'd2;
      endcase
   endfunction

   // Issue one instruction starting at the current negedge and act as the
   // bus: addr_ok on cycle a_lat, data_ok on cycle d_lat (d_lat >= a_lat).
   task automatic run_instr(input mem_op_t op, input logic [31:0] addr, input logic [4:0] rd,
                            input logic [31:0] sdata, input logic [31:0] rdata,
                            input int a_lat, input int d_lat);
      bit seen = 0, adone = 0, aok, dok;
      in_valid = 1'b1;
      memop = op; alu_out = addr; rd_in = rd; store_data = sdata;
      bus.dresp_addr_ok = 1'b0; bus.dresp_data_ok = 1'b0; bus.dresp_data = $urandom;
      o_k = -1; o_req = 0; o_stall = 0; o_unst = 0;
      o_wen = 1'bx; o_mis = 1'bx; o_rd = 'x; o_res = 'x;
      o_addr = 'x; o_size = 'x; o_strb = 'x; o_data = 'x;
      @(posedge clk);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         memop = mem_op_t'($urandom_range(0, 8));
         alu_out = $urandom; rd_in = 5'($urandom); store_data = $urandom;
         if (bus.dreq_valid) begin
            o_req++;
            if (!seen) begin
               seen = 1; o_addr = bus.dreq_addr; o_size = bus.dreq_size;
               o_strb = bus.dreq_strobe; o_data = bus.dreq_data;
            end else if (o_addr !== bus.dreq_addr || o_size !== bus.dreq_size ||
                         o_strb !== bus.dreq_strobe || o_data !== bus.dreq_data) begin
               o_unst++;
            end
         end
         if (!in_ready) o_stall++;
         if (wb_valid) begin
            o_k = k; o_wen = wb_wen; o_mis = misalign; o_rd = wb_rd; o_res = wb_result;
            break;
         end
         aok = bus.dreq_valid && k == a_lat;
         dok = (adone || aok) && k == d_lat;
         adone = adone || aok;
         bus.dresp_addr_ok = aok;
         bus.dresp_data_ok = dok;
         bus.dresp_data = dok ? rdata : $urandom;
      end
      bus.dresp_addr_ok = 1'b0; bus.dresp_data_ok = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; memop = MEM_NONE; rd_in = '0; alu_out = '0; store_data = '0;
      bus.dresp_addr_ok = 1'b0; bus.dresp_data_ok = 1'b0; bus.dresp_data = '0;
      repeat (3) @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
      total++; if (bus.dreq_valid !== 1'b0) begin bad++; $display("FAIL rst_dreq_valid got=%b want=0", bus.dreq_valid); end
      total++; if ({wb_valid, wb_wen, misalign} !== 3'b000) begin bad++; $display("FAIL rst_wb_flags got=%b want=000", {wb_valid, wb_wen, misalign}); end
      total++; if (wb_rd !== 5'd0) begin bad++; $display("FAIL rst_wb_rd got=%0d want=0", wb_rd); end
      total++; if (wb_result !== 32'd0) begin bad++; $display("FAIL rst_wb_result got=%h want=0", wb_result); end
      total++; if (bus.dreq_addr !== 32'd0 || bus.dreq_strobe !== 4'd0) begin bad++; $display("FAIL rst_req_regs got=%h/%b want=0/0", bus.dreq_addr, bus.dreq_strobe); end
      reset = 1'b0;
   endtask

   task automatic test_none();
      run_instr(MEM_NONE, 32'h1234, 5'd3, 32'h0, 32'h0, 1, 1);
      total++; if (o_k !== 1) begin bad++; $display("FAIL none_latency got=%0d want=1", o_k); end
      total++; if (o_res !== 32'h1234) begin bad++; $display("FAIL none_result got=%h want=00001234", o_res); end
      total++; if (o_wen !== 1'b1 || o_rd !== 5'd3) begin bad++; $display("FAIL none_wen_rd got=%b/%0d want=1/3", o_wen, o_rd); end
      total++; if (o_req !== 0) begin bad++; $display("FAIL none_no_req got=%0d want=0", o_req); end
   endtask

   task automatic test_lw_fast();
      run_instr(MEM_LW, 32'h100, 5'd5, 32'h0, 32'hDEADBEEF, 1, 1);
      total++; if (o_k !== 2) begin bad++; $display("FAIL lw_latency got=%0d want=2", o_k); end
      total++; if (o_res !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_result got=%h want=deadbeef", o_res); end
      total++; if (o_size !== 2'd2 || o_strb !== 4'b0000 || o_addr !== 32'h100) begin bad++; $display("FAIL lw_req got=%0d/%b/%h want=2/0000/00000100", o_size, o_strb, o_addr); end
      total++; if (o_wen !== 1'b1) begin bad++; $display("FAIL lw_wen got=%b want=1", o_wen); end
   endtask

   task automatic test_lb_slow();
      run_instr(MEM_LB, 32'h103, 5'd7, 32'h0, 32'h80FF_0000, 1, 4);
      total++; if (o_k !== 5) begin bad++; $display("FAIL lb_latency got=%0d want=5", o_k); end
      total++; if (o_stall !== 4) begin bad++; $display("FAIL lb_stall got=%0d want=4", o_stall); end
      total++; if (o_res !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_result got=%h want=ffffff80", o_res); end
      run_instr(MEM_LBU, 32'h103, 5'd7, 32'h0, 32'h80FF_0000, 1, 4);
      total++; if (o_res !== 32'h0000_0080) begin bad++; $display("FAIL lbu_result got=%h want=00000080", o_res); end
   endtask

   task automatic test_store();
      run_instr(MEM_SH, 32'h102, 5'd9, 32'hAAAA_5678, 32'h0, 2, 3);
      total++; if (o_strb !== 4'b1100) begin bad++; $display("FAIL sh_strobe got=%b want=1100", o_strb); end
      total++; if (o_data !== 32'h5678_5678) begin bad++; $display("FAIL sh_data got=%h want=56785678", o_data); end
      total++; if (o_size !== 2'd1) begin bad++; $display("FAIL sh_size got=%0d want=1", o_size); end
      total++; if (o_wen !== 1'b0 || o_k !== 4) begin bad++; $display("FAIL sh_wb got=%b/%0d want=0/4", o_wen, o_k); end
      total++; if (o_req !== 2 || o_unst !== 0) begin bad++; $display("FAIL sh_req_hold got=%0d/%0d want=2/0", o_req, o_unst); end
   endtask

   task automatic test_misalign();
      run_instr(MEM_LW, 32'h101, 5'd4, 32'h0, 32'h0, 1, 1);
      total++; if (o_mis !== 1'b1 || o_k !== 1) begin bad++; $display("FAIL mis_flag got=%b@%0d want=1@1", o_mis, o_k); end
      total++; if (o_wen !== 1'b0) begin bad++; $display("FAIL mis_wen got=%b want=0", o_wen); end
      total++; if (o_req !== 0) begin bad++; $display("FAIL mis_no_req got=%0d want=0", o_req); end
   endtask

   task automatic test_reset_mid();
      int late = 0;
      in_valid = 1'b1; memop = MEM_LB; alu_out = 32'h40; rd_in = 5'd2; store_data = '0;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      total++; if (bus.dreq_valid !== 1'b1) begin bad++; $display("FAIL rmid_req got=%b want=1", bus.dreq_valid); end
      bus.dresp_addr_ok = 1'b1;
      @(negedge clk);
      bus.dresp_addr_ok = 1'b0;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rmid_data_wait got=%b want=0", in_ready); end
      reset = 1'b1;
      @(negedge clk);
      total++; if ({in_ready, bus.dreq_valid, wb_valid} !== 3'b100) begin bad++; $display("FAIL rmid_after got=%b want=100", {in_ready, bus.dreq_valid, wb_valid}); end
      reset = 1'b0;
      bus.dresp_data_ok = 1'b1; bus.dresp_data = 32'h1234_5678;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.dresp_data_ok = 1'b0;
         if (wb_valid) late++;
      end
      total++; if (late !== 0) begin bad++; $display("FAIL rmid_late_wb got=%0d want=0", late); end
      // Reset while the request is still in ADDR.
      in_valid = 1'b1; memop = MEM_LW; alu_out = 32'h80;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      total++; if (bus.dreq_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL raddr_after got=%b/%b want=0/1", bus.dreq_valid, in_ready); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      run_instr(MEM_NONE, 32'hCAFE, 5'd1, 32'h0, 32'h0, 1, 1);
      run_instr(MEM_LHU, 32'h202, 5'd6, 32'h0, 32'h8765_4321, 1, 2);
      total++; if (o_k !== 3 || o_res !== 32'h0000_8765) begin bad++; $display("FAIL b2b_lhu got=%h@%0d want=00008765@3", o_res, o_k); end
      run_instr(MEM_NONE, 32'hBEEF, 5'd0, 32'h0, 32'h0, 1, 1);
      total++; if (o_k !== 1 || o_wen !== 1'b0 || o_res !== 32'hBEEF) begin bad++; $display("FAIL b2b_none_rd0 got=%h/%b@%0d want=0000beef/0@1", o_res, o_wen, o_k); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 60; it++) begin
         mem_op_t op;
         logic [31:0] a, sd, rdv;
         logic [4:0] rd;
         int al, dl, opi;
         bit mem;
         opi = $urandom_range(0, 8);
         op  = mem_op_t'(opi);
         a   = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & ~32'd3 | (a & (m_bytes(opi) == 2 ? 32'd2 : m_bytes(opi) == 1 ? 32'd3 : 32'd0));
         rd  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
         sd  = $urandom; rdv = $urandom;
         al  = $urandom_range(1, 3); dl = al + $urandom_range(0, 3);
         mem = opi != 0 && !m_misaligned(opi, a);
         run_instr(op, a, rd, sd, rdv, al, dl);
         total++; if (o_k !== (mem ? dl + 1 : 1)) begin bad++; $display("FAIL rnd_latency op=%0d got=%0d want=%0d", opi, o_k, mem ? dl + 1 : 1); end
         total++; if (o_mis !== (opi != 0 && m_misaligned(opi, a))) begin bad++; $display("FAIL rnd_misalign op=%0d a=%h got=%b", opi, a, o_mis); end
         total++; if (o_rd !== rd) begin bad++; $display("FAIL rnd_rd got=%0d want=%0d", o_rd, rd); end
         total++; if (o_wen !== ((opi == 0 || (mem && m_is_load(opi))) && rd != 0)) begin bad++; $display("FAIL rnd_wen op=%0d got=%b", opi, o_wen); end
         if (opi == 0) begin
            total++; if (o_res !== a) begin bad++; $display("FAIL rnd_none_res got=%h want=%h", o_res, a); end
         end
         if (mem) begin
            if (m_is_load(opi)) begin
               total++; if (o_res !== m_load_val(opi, a, rdv)) begin bad++; $display("FAIL rnd_load op=%0d a=%h raw=%h got=%h want=%h", opi, a, rdv, o_res, m_load_val(opi, a, rdv)); end
            end else begin
               total++; if (o_data !== m_lane(opi, sd)) begin bad++; $display("FAIL rnd_sdata op=%0d got=%h want=%h", opi, o_data, m_lane(opi, sd)); end
            end
            total++; if (o_strb !== m_strobe(opi, a) || o_size !== m_size(opi) || o_addr !== a) begin bad++; $display("FAIL rnd_req op=%0d got=%b/%0d/%h want=%b/%0d/%h", opi, o_strb, o_size, o_addr, m_strobe(opi, a), m_size(opi), a); end
            total++; if (o_req !== al || o_unst !== 0 || o_stall !== dl) begin bad++; $display("FAIL rnd_timing got=%0d/%0d/%0d want=%0d/0/%0d", o_req, o_unst, o_stall, al, dl); end
         end else begin
            total++; if (o_req !== 0) begin bad++; $display("FAIL rnd_no_req op=%0d got=%0d want=0", opi, o_req); end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_none();
      test_lw_fast();
      test_lb_slow();
      test_store();
      test_misalign();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
